gdt_row_reader: RTL and testbench
=================================

GDT_ROW_READER -- requirements
Module: gdt_row_reader

Interface
REQ-001 Parameter GDT_RD_LATENCY, default 1, cycles from a GDT read strobe to valid gdt_rdata; the only supported value is 1.
REQ-002 clock  in  1  single system clock; all logic on its rising edge.
REQ-003 reset_n  in  1  reset, asynchronous and active-low.
REQ-004 req_valid  in  1  row-read request present.
REQ-005 req_ready  out  1  request accepted when req_valid && req_ready.
REQ-006 req_guest  in  3  guest line to read.
REQ-007 req_first_col  in  3  first GDT column.
REQ-008 req_count  in  4  number of columns, legal range 1..8.
REQ-009 gdt_enable  out  1  GDT access strobe.
REQ-010 gdt_line  out  3  GDT guest line.
REQ-011 gdt_column  out  3  GDT column.
REQ-012 gdt_rd0_wr1  out  1  GDT direction; this block only reads, so it is tied to 0.
REQ-013 gdt_rdata  in  32  GDT read data.
REQ-014 out_valid  out  1  word available.
REQ-015 out_ready  in  1  consumer accepts the word when out_valid && out_ready.
REQ-016 out_data  out  32  descriptor word.
REQ-017 out_column  out  3  column of out_data.
REQ-018 out_last  out  1  final word of the request.
REQ-019 busy  out  1  high in every state except IDLE.
REQ-020 err  out  1  one-cycle pulse on an illegal request.

Function
REQ-021 States: IDLE, ISSUE, CAPTURE, HOLD.
REQ-022 req_ready SHALL equal (state==IDLE).
REQ-023 On acceptance, guest, column and remaining count SHALL be latched; a later req_* change SHALL have no effect.
REQ-024 A request with req_count==0 or req_first_col+req_count>8 SHALL be accepted, produce err=1 for exactly the next cycle, issue no GDT access and stay in IDLE.
REQ-025 A legal request SHALL move IDLE->ISSUE.
REQ-026 In ISSUE, the block SHALL drive gdt_enable=1 and the latched line/column for exactly one cycle, then go to CAPTURE; gdt_enable SHALL be 0 in all other states.
REQ-027 In CAPTURE, the block SHALL register gdt_rdata into out_data and set out_valid=1, out_column=current column and out_last=(remaining==1), then go to HOLD.
REQ-028 In HOLD, out_valid and out_data SHALL remain stable until out_ready; on acceptance out_valid SHALL drop the next cycle.
REQ-029 On acceptance in HOLD, the next state SHALL be IDLE if out_last, else ISSUE with column+1 and remaining-1.
REQ-030 Column arithmetic is 3-bit; by REQ-024 it never wraps past 7.
REQ-031 Timing: request accepted at edge N gives gdt_enable at N+1 and out_valid at N+3; with out_ready held at 1, one word per 3 cycles.
REQ-032 out_valid SHALL never be asserted while a GDT read is in flight.

Reset
REQ-033 Asserting reset_n low SHALL immediately force state=IDLE and clear out_valid, out_last, err, gdt_enable, gdt_rd0_wr1, out_data, out_column, gdt_line, gdt_column and busy.
REQ-034 Reset mid-request SHALL abandon the request with no further GDT access or output word.
REQ-035 After release, req_ready=1 on the first edge.

Structure
REQ-036 A shared package SHALL hold the state enumeration, GDT_LINE_W=3, GDT_COL_W=3, GDT_DATA_W=32 and GDT_COLS=8.
REQ-037 Single module; no sub-module is required.

Verification
REQ-038 Model the GDT as 8x8 words with 1-cycle read latency and fill each word as {line,column,26'h0}. Request guest 0, first_col 1, count 1, out_ready=1 -> one read of line 0 col 1; out_data=32'h0400_0000, out_last=1, out_valid at acceptance+3.
REQ-039 Request guest 5, first_col 0, count 8 -> 8 reads, columns 0..7 in order; out_last only on column 7; busy low after the last handshake.
REQ-040 Request guest 2, first_col 6, count 3 -> err pulse of one cycle, no gdt_enable, req_ready back high next cycle; then count 0 -> same response.
REQ-041 Request guest 3, col 2, count 2, out_ready low for 5 cycles on the first word -> out_data/out_column stable in HOLD, no second read until the handshake.
REQ-042 Assert reset_n during CAPTURE of the second word of a count-4 request -> outputs cleared at once, no further gdt_enable; a new request afterwards completes normally.

Source files
------------

// File: rtl/gdt_row_reader_pkg.sv
// gdt_row_reader_pkg: shared widths and FSM states for the GDT row reader
package gdt_row_reader_pkg;
  localparam int GDT_LINE_W = 3;
  localparam int GDT_COL_W  = 3;
  localparam int GDT_DATA_W = 32;
  localparam int GDT_COLS   = 8;
  localparam int GDT_CNT_W  = 4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_CAPTURE,
    ST_HOLD
  } state_t;
endpackage

// File: rtl/gdt_row_reader_if.sv
// gdt_row_reader_if: request, GDT port and output word channel of the row reader
interface gdt_row_reader_if;
  import gdt_row_reader_pkg::*;
  logic                  req_valid;
  logic                  req_ready;
  logic [GDT_LINE_W-1:0] req_guest;
  logic [GDT_COL_W-1:0]  req_first_col;
  logic [GDT_CNT_W-1:0]  req_count;
  logic                  gdt_enable;
  logic [GDT_LINE_W-1:0] gdt_line;
  logic [GDT_COL_W-1:0]  gdt_column;
  logic                  gdt_rd0_wr1;
  logic [GDT_DATA_W-1:0] gdt_rdata;
  logic                  out_valid;
  logic                  out_ready;
  logic [GDT_DATA_W-1:0] out_data;
  logic [GDT_COL_W-1:0]  out_column;
  logic                  out_last;

  modport master (
    output req_valid, req_guest, req_first_col, req_count, gdt_rdata, out_ready,
    input  req_ready, gdt_enable, gdt_line, gdt_column, gdt_rd0_wr1,
           out_valid, out_data, out_column, out_last
  );

  modport slave (
    input  req_valid, req_guest, req_first_col, req_count, gdt_rdata, out_ready,
    output req_ready, gdt_enable, gdt_line, gdt_column, gdt_rd0_wr1,
           out_valid, out_data, out_column, out_last
  );
endinterface

// File: rtl/gdt_row_reader.sv
// gdt_row_reader: reads a run of GDT columns for one guest line and streams the words out
module gdt_row_reader
  import gdt_row_reader_pkg::*;
#(
  parameter int GDT_RD_LATENCY = 1
) (
  input  logic           clock,
  input  logic           reset_n,
  gdt_row_reader_if.slave bus,
  output logic           busy,
  output logic           err
);
  if (GDT_RD_LATENCY != 1) begin : g_lat_check
    $error("gdt_row_reader supports only GDT_RD_LATENCY == 1");
  end

  state_t                state, state_next;
  logic [GDT_LINE_W-1:0] line_q;
  logic [GDT_COL_W-1:0]  col_q;
  logic [GDT_CNT_W-1:0]  rem_q;
  logic                  accept;
  logic                  legal;

  assign accept = bus.req_valid && bus.req_ready;
  assign legal  = (bus.req_count != '0) &&
                  (({2'b00, bus.req_first_col} + {1'b0, bus.req_count}) <= 5'(GDT_COLS));

  // state register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_next;
  end

  // next-state: one GDT read and one output handshake per column
  always_comb begin
    state_next = state;
    unique case (state)
      ST_IDLE:    state_next = (accept && legal) ? ST_ISSUE : ST_IDLE;
      ST_ISSUE:   state_next = ST_CAPTURE;
      ST_CAPTURE: state_next = ST_HOLD;
      ST_HOLD:    state_next = bus.out_ready ? (bus.out_last ? ST_IDLE : ST_ISSUE) : ST_HOLD;
      default:    state_next = ST_IDLE;
    endcase
  end

  // state-decoded outputs; the GDT address comes straight from the latched request
  always_comb begin
    bus.req_ready   = (state == ST_IDLE);
    bus.gdt_enable  = (state == ST_ISSUE);
    bus.gdt_rd0_wr1 = 1'b0;
    bus.gdt_line    = line_q;
    bus.gdt_column  = col_q;
    busy            = (state != ST_IDLE);
  end

  // request latch, column walk, output word register and error pulse
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      line_q         <= '0;
      col_q          <= '0;
      rem_q          <= '0;
      err            <= 1'b0;
      bus.out_valid  <= 1'b0;
      bus.out_data   <= '0;
      bus.out_column <= '0;
      bus.out_last   <= 1'b0;
    end else begin
      err <= accept && !legal;
      if (accept && legal) begin
        line_q <= bus.req_guest;
        col_q  <= bus.req_first_col;
        rem_q  <= bus.req_count;
      end
      if (state == ST_CAPTURE) begin
        bus.out_valid  <= 1'b1;
        bus.out_data   <= bus.gdt_rdata;
        bus.out_column <= col_q;
        bus.out_last   <= (rem_q == 4'd1);
      end
      if (state == ST_HOLD && bus.out_ready) begin
        bus.out_valid <= 1'b0;
        if (!bus.out_last) begin
          col_q <= col_q + 3'd1;
          rem_q <= rem_q - 4'd1;
        end
      end
    end
  end
endmodule

// File: tb/tb_gdt_row_reader.sv
// tb_gdt_row_reader: scoreboard bench with an 8x8 GDT model of 1-cycle read latency
module tb_gdt_row_reader;
  typedef struct packed {
    logic [31:0] data;
    logic [2:0]  col;
    logic        last;
  } exp_t;

  logic clock;
  logic reset_n;
  logic busy;
  logic err;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  int   en_count = 0;
  int   err_cycles = 0;
  int   first_en = -1;
  int   first_ov = -1;
  int   acc_cyc = 0;
  exp_t sb[$];
  logic [5:0] rd_q[$];
  logic        stall_prev = 1'b0;
  logic [31:0] prev_data = '0;
  logic [2:0]  prev_col = '0;

  gdt_row_reader_if bus ();

  gdt_row_reader #(.GDT_RD_LATENCY(1)) dut (
    .clock  (clock),
    .reset_n(reset_n),
    .bus    (bus),
    .busy   (busy),
    .err    (err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  // GDT model: word = {line, column, 26'h0}, valid the cycle after the strobe
  always @(posedge clock) begin
    if (bus.gdt_enable) bus.gdt_rdata <= {bus.gdt_line, bus.gdt_column, 26'h0};
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // monitor: GDT addresses, output words, HOLD stability and error pulses
  always @(negedge clock) begin
    if (reset_n) begin
      if (bus.gdt_enable) begin
        en_count++;
        if (first_en < 0) first_en = cyc;
        check("rd0_wr1", 32'(bus.gdt_rd0_wr1), 0);
        if (rd_q.size() == 0) check("rd_unexpected", 1, 0);
        else check("gdt_addr", 32'({bus.gdt_line, bus.gdt_column}), 32'(rd_q.pop_front()));
      end
      if (bus.out_valid && bus.gdt_enable) check("valid_in_flight", 1, 0);
      if (bus.out_valid && first_ov < 0) first_ov = cyc;
      if (stall_prev && bus.out_valid) begin
        check("hold_data", bus.out_data, prev_data);
        check("hold_col", 32'(bus.out_column), 32'(prev_col));
      end
      if (bus.out_valid && bus.out_ready) begin
        if (sb.size() == 0) check("word_unexpected", 1, 0);
        else begin
          exp_t e;
          e = sb.pop_front();
          check("out_data", bus.out_data, e.data);
          check("out_column", 32'(bus.out_column), 32'(e.col));
          check("out_last", 32'(bus.out_last), 32'(e.last));
        end
      end
      if (err) err_cycles++;
    end
    stall_prev = bus.out_valid && !bus.out_ready;
    prev_data  = bus.out_data;
    prev_col   = bus.out_column;
  end

  task automatic send(input int g, input int c, input int n);
    int t = 0;
    while (!bus.req_ready && t < 100) begin
      @(posedge clock);
      #1;
      t++;
    end
    check("req_ready_wait", 32'(t < 100), 1);
    bus.req_valid     = 1'b1;
    bus.req_guest     = 3'(g);
    bus.req_first_col = 3'(c);
    bus.req_count     = 4'(n);
    if (n != 0 && c + n <= 8)
      for (int i = 0; i < n; i++) begin
        rd_q.push_back({3'(g), 3'(c + i)});
        sb.push_back('{data: {3'(g), 3'(c + i), 26'h0}, col: 3'(c + i), last: (i == n - 1)});
      end
    @(posedge clock);
    #1;
    acc_cyc           = cyc;
    bus.req_valid     = 1'b0;
    bus.req_guest     = 3'($urandom);
    bus.req_first_col = 3'($urandom);
    bus.req_count     = 4'($urandom);
  endtask

  task automatic wait_idle();
    int t = 0;
    while ((sb.size() != 0 || busy) && t < 200) begin
      @(posedge clock);
      #1;
      t++;
    end
    check("idle_timeout", 32'(t < 200), 1);
  endtask

  task automatic start_req_stats();
    en_count = 0;
    first_en = -1;
    first_ov = -1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.req_valid     = 1'b0;
    bus.req_guest     = '0;
    bus.req_first_col = '0;
    bus.req_count     = '0;
    bus.out_ready     = 1'b1;
    reset_n           = 1'b1;
    #2 reset_n = 1'b0;
    #1;
    check("rst_req_ready", 32'(bus.req_ready), 1);
    check("rst_busy", 32'(busy), 0);
    check("rst_err", 32'(err), 0);
    check("rst_out_valid", 32'(bus.out_valid), 0);
    check("rst_gdt_enable", 32'(bus.gdt_enable), 0);
    check("rst_out_data", bus.out_data, 0);
    repeat (2) @(posedge clock);
    #1 reset_n = 1'b1;
    @(posedge clock);
    #1;
    check("ready_after_rst", 32'(bus.req_ready), 1);

    start_req_stats();
    send(0, 1, 1);
    check("t1_busy", 32'(busy), 1);
    wait_idle();
    check("t1_en_cycle", 32'(first_en), 32'(acc_cyc));
    check("t1_ov_cycle", 32'(first_ov), 32'(acc_cyc + 2));
    check("t1_reads", 32'(en_count), 1);

    start_req_stats();
    send(5, 0, 8);
    wait_idle();
    check("t2_reads", 32'(en_count), 8);
    check("t2_busy_low", 32'(busy), 0);
    check("t2_ready", 32'(bus.req_ready), 1);

    start_req_stats();
    err_cycles = 0;
    send(2, 6, 3);
    check("t3_err_pulse", 32'(err), 1);
    check("t3_ready", 32'(bus.req_ready), 1);
    check("t3_busy", 32'(busy), 0);
    @(posedge clock);
    #1;
    check("t3_err_drop", 32'(err), 0);
    send(2, 6, 0);
    check("t3_err_pulse_c0", 32'(err), 1);
    check("t3_ready_c0", 32'(bus.req_ready), 1);
    @(posedge clock);
    #1;
    check("t3_err_drop_c0", 32'(err), 0);
    repeat (2) @(posedge clock);
    #1;
    check("t3_no_reads", 32'(en_count), 0);
    check("t3_err_cycles", 32'(err_cycles), 2);

    start_req_stats();
    bus.out_ready = 1'b0;
    send(3, 2, 2);
    begin
      int t = 0;
      while (!bus.out_valid && t < 20) begin
        @(posedge clock);
        #1;
        t++;
      end
      check("t4_valid_wait", 32'(t < 20), 1);
    end
    repeat (5) @(posedge clock);
    #1;
    check("t4_stall_valid", 32'(bus.out_valid), 1);
    check("t4_one_read", 32'(en_count), 1);
    bus.out_ready = 1'b1;
    wait_idle();
    check("t4_reads", 32'(en_count), 2);

    start_req_stats();
    send(1, 0, 4);
    repeat (4) @(posedge clock);
    #1 reset_n = 1'b0;
    #1;
    check("t5_rst_valid", 32'(bus.out_valid), 0);
    check("t5_rst_busy", 32'(busy), 0);
    check("t5_rst_enable", 32'(bus.gdt_enable), 0);
    check("t5_rst_data", bus.out_data, 0);
    check("t5_rst_col", 32'({bus.out_column, bus.gdt_column, bus.gdt_line}), 0);
    check("t5_rst_last", 32'(bus.out_last), 0);
    check("t5_reads_before", 32'(en_count), 2);
    sb.delete();
    rd_q.delete();
    start_req_stats();
    repeat (2) @(posedge clock);
    #1 reset_n = 1'b1;
    repeat (4) @(posedge clock);
    #1;
    check("t5_no_reads_after", 32'(en_count), 0);
    check("t5_no_word_after", 32'(first_ov), 32'(-1));
    send(6, 3, 5);
    wait_idle();
    check("t5_new_reads", 32'(en_count), 5);
    check("t5_new_ov_cycle", 32'(first_ov), 32'(acc_cyc + 2));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
